// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and registers the
// returned word toward decode through a valid/ready stage. Define FETCH_HALT_EN to stop on HALT_WORD.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        fetch_en,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        halted
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic        load;
   logic        transfer;
   logic        halt_hit;

   assign imem_addr = pc;
   assign transfer  = inst_valid && inst_ready;
   assign load      = (state == RUN) && (!inst_valid || inst_ready) && !redirect;

`ifdef FETCH_HALT_EN
   assign halt_hit = load && (imem_data == HALT_WORD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted <= 1'b0;
      end else if (redirect) begin
         halted <= 1'b0;
      end else if (halt_hit) begin
         halted <= 1'b1;
      end
   end
`else
   logic unused_halt_word;
   assign unused_halt_word = ^HALT_WORD;
   assign halt_hit         = 1'b0;
   assign halted           = 1'b0;
`endif

   // Redirect outranks both load and stall; the halt word itself is still delivered to decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
         inst_valid <= 1'b0;
         state      <= IDLE;
      end else if (redirect) begin
         pc         <= redirect_pc;
         inst_valid <= 1'b0;
         if (state == HALT) begin
            state <= fetch_en ? RUN : IDLE;
         end
      end else begin
         if (load) begin
            inst       <= imem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + 32'd1;
         end else if (transfer) begin
            inst_valid <= 1'b0;
         end

         if (halt_hit) begin
            state <= HALT;
         end else begin
            case (state)
               IDLE:    if (fetch_en)  state <= RUN;
               RUN:     if (!fetch_en) state <= IDLE;
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: expected instruction stream kept as a queue of (pc, word) that a
// negedge monitor consumes on every accepted transfer; directed phases plus a random phase.
module tb_fetch_unit;

   localparam logic [31:0] NO_HALT = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        fetch_en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        halted;

   logic        w_rst;
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_data;
   logic        w_fetch_en;
   logic        w_inst_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_halted;

   logic [31:0] halt_addr;

   int total = 0;
   int bad = 0;
   int n_xfer = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t sb[$];

   // Memory image: word at address a is 0x1000_0000 + a, except the planted halt word.
   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
      if (a == h) return 32'hFFFF_FFFF;
      return 32'h1000_0000 + a;
   endfunction

   assign imem_data   = mem_word(imem_addr, halt_addr);
   assign w_imem_data = mem_word(w_imem_addr, NO_HALT);

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .halted(halted)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
      .clk(clk), .rst(w_rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
      .fetch_en(w_fetch_en), .redirect(1'b0), .redirect_pc(32'h0),
      .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst(w_inst),
      .inst_pc(w_inst_pc), .halted(w_halted)
   );

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", name, got, want);
      end
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = start + 32'(i);
         sb.push_back('{pc: a, word: mem_word(a, halt_addr)});
      end
   endtask

   // A redirect restarts the architectural instruction stream at rpc.
   task automatic apply_stimulus(input logic en, input logic rdy, input logic rd,
                                 input logic [31:0] rpc, input int depth);
      fetch_en    = en;
      inst_ready  = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      if (rd) begin
         sb.delete();
         push_seq(rpc, depth);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int target, input int limit, input string name);
      int c;
      c = 0;
      while (sb.size() > target && c < limit) begin
         step();
         c++;
      end
      if (sb.size() > target) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: queue depth %0d after %0d cycles, expected <= %0d",
                  name, sb.size(), limit, target);
      end
   endtask

   // Monitor: consumes the expected stream and checks stall stability and redirect flush.
   logic        have_prev = 1'b0;
   logic        prev_redirect;
   logic        prev_stall;
   logic [31:0] prev_inst;
   logic [31:0] prev_pc;
   logic [31:0] prev_addr;
   exp_t        e;

   always @(negedge clk) begin
      if (rst) begin
         have_prev = 1'b0;
      end else begin
         if (have_prev && prev_redirect) begin
            check_bit("redirect_flush", inst_valid, 1'b0);
         end else if (have_prev && prev_stall) begin
            check_bit("stall_valid", inst_valid, 1'b1);
            check_output("stall_inst", inst, prev_inst);
            check_output("stall_inst_pc", inst_pc, prev_pc);
            check_output("stall_imem_addr", imem_addr, prev_addr);
         end
         if (inst_valid && inst_ready && !redirect) begin
            n_xfer++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_transfer: got inst_pc %h with nothing expected", inst_pc);
            end else begin
               e = sb.pop_front();
               check_output("xfer_pc", inst_pc, e.pc);
               check_output("xfer_inst", inst, e.word);
            end
         end
         prev_redirect = redirect;
         prev_stall    = inst_valid && !inst_ready && !redirect;
         prev_inst     = inst;
         prev_pc       = inst_pc;
         prev_addr     = imem_addr;
         have_prev     = 1'b1;
      end
   end

   initial begin
      rst         = 1'b1;
      w_rst       = 1'b1;
      w_fetch_en  = 1'b1;
      fetch_en    = 1'b0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      halt_addr   = NO_HALT;
      step();
      step();
      check_bit("reset_valid", inst_valid, 1'b0);
      check_output("reset_addr", imem_addr, 32'h0);
      check_output("reset_inst", inst, 32'h0);
      check_output("reset_inst_pc", inst_pc, 32'h0);
      check_bit("reset_halted", halted, 1'b0);

      // Startup latency and streaming
      push_seq(32'h0, 200);
      rst = 1'b0;
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 0);
      step();
      check_bit("first_edge_valid", inst_valid, 1'b0);
      step();
      check_bit("second_edge_valid", inst_valid, 1'b1);
      check_output("first_inst_pc", inst_pc, 32'h0);
      check_output("first_inst", inst, 32'h1000_0000);
      for (int k = 1; k <= 5; k++) begin
         step();
         check_output("stream_pc", inst_pc, 32'(k));
      end

      // Stall with inst_pc=5
      inst_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_output("hold_inst", inst, 32'h1000_0005);
         check_output("hold_inst_pc", inst_pc, 32'h5);
         check_output("hold_imem_addr", imem_addr, 32'h6);
      end
      inst_ready = 1'b1;
      step();
      check_output("release_pc", inst_pc, 32'h6);
      step();
      step();

      // Redirect while stalled
      inst_ready = 1'b0;
      step();
      apply_stimulus(1'b1, 1'b0, 1'b1, 32'h40, 200);
      step();
      redirect = 1'b0;
      check_bit("redirect_bubble", inst_valid, 1'b0);
      check_output("redirect_addr", imem_addr, 32'h40);
      step();
      check_bit("redirect_first_valid", inst_valid, 1'b1);
      check_output("redirect_first_pc", inst_pc, 32'h40);
      check_output("redirect_first_inst", inst, 32'h1000_0040);
      inst_ready = 1'b1;

      // Halt word planted at address 3
      halt_addr = 32'h3;
`ifdef FETCH_HALT_EN
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0, 4);
      step();
      redirect = 1'b0;
      wait_drain(0, 50, "halt_drain");
      check_bit("halted_set", halted, 1'b1);
      check_bit("halted_valid", inst_valid, 1'b0);
      check_output("halted_addr", imem_addr, 32'h4);
      for (int k = 0; k < 2; k++) begin
         step();
         check_output("halted_addr_frozen", imem_addr, 32'h4);
         check_bit("halted_still_idle", inst_valid, 1'b0);
      end
`else
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0, 200);
      step();
      redirect = 1'b0;
      wait_drain(190, 50, "halt_word_plain_drain");
      check_bit("halt_word_plain", halted, 1'b0);
`endif
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'h8, 100);
      step();
      redirect = 1'b0;
      check_bit("resume_halted_clear", halted, 1'b0);
      check_bit("resume_bubble", inst_valid, 1'b0);
      step();
      check_bit("resume_valid", inst_valid, 1'b1);
      check_output("resume_pc", inst_pc, 32'h8);
      halt_addr = NO_HALT;

      // Random phase
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'($urandom_range(0, 1000)), 700);
      for (int c = 0; c < 600; c++) begin
         step();
         if ($urandom_range(0, 19) == 0) begin
            apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'b1,
                           32'($urandom_range(0, 1000)), 700);
         end else begin
            apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'b0,
                           32'h0, 0);
         end
      end
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 0);
      step();
      step();
      check_bit("transfers_seen", n_xfer > 100, 1'b1);

      // Asynchronous reset in the middle of a stall
      apply_stimulus(1'b1, 1'b0, 1'b1, 32'h6, 50);
      step();
      redirect = 1'b0;
      step();
      check_bit("pre_reset_valid", inst_valid, 1'b1);
      check_output("pre_reset_inst_pc", inst_pc, 32'h6);
      check_output("pre_reset_addr", imem_addr, 32'h7);
      #2;
      rst = 1'b1;
      #1;
      check_bit("async_reset_valid", inst_valid, 1'b0);
      check_output("async_reset_addr", imem_addr, 32'h0);
      check_output("async_reset_inst", inst, 32'h0);
      check_output("async_reset_inst_pc", inst_pc, 32'h0);
      check_bit("async_reset_halted", halted, 1'b0);
      step();
      sb.delete();
      push_seq(32'h0, 50);
      rst        = 1'b0;
      inst_ready = 1'b1;
      step();
      check_bit("restart_first_edge", inst_valid, 1'b0);
      step();
      check_bit("restart_valid", inst_valid, 1'b1);
      check_output("restart_pc", inst_pc, 32'h0);
      check_output("restart_inst", inst, 32'h1000_0000);
      fetch_en = 1'b0;
      step();
      step();

      // PC wrap from RESET_PC = FFFF_FFFE
      w_rst = 1'b0;
      step();
      check_bit("wrap_first_edge", w_inst_valid, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_bit("wrap_valid", w_inst_valid, 1'b1);
         check_output("wrap_pc", w_inst_pc, 32'hFFFF_FFFE + 32'(k));
         check_output("wrap_inst", w_inst, mem_word(32'hFFFF_FFFE + 32'(k), NO_HALT));
      end
      check_output("wrap_addr", w_imem_addr, 32'h1);
      check_bit("wrap_halted", w_halted, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
